// File: rtl/dm_rmw_ctrl_pkg.sv
// Shared pipeline definitions for the data-memory controllers.
// Access-size encodings and the read-modify-write FSM states.
package dm_rmw_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } dm_size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } dm_state_e;

  // True for a byte or half access (needs read-modify-write on store).
  function automatic logic size_is_sub(input logic [1:0] s);
    return (s == SZ_BYTE) || (s == SZ_HALF);
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte/half lane extraction for loads and lane merge for stores.
// Purely combinational; word is the current DM (or latched) word.
module dm_lane_unit
  import dm_rmw_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [31:0] ext_load,
  output logic [31:0] merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and half lanes.
  always_comb begin
    w_byte = word[7:0];
    case (addr)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = addr[1] ? word[31:16] : word[15:0];
  end

  // Zero- or sign-extend the selected lane for loads.
  always_comb begin
    ext_load = word;
    case (size)
      SZ_BYTE: ext_load = {{24{sign & w_byte[7]}}, w_byte};
      SZ_HALF: ext_load = {{16{sign & w_half[15]}}, w_half};
      default: ext_load = word;
    endcase
  end

  // Replace the addressed lane with store data; words pass wdata.
  always_comb begin
    merged_word = word;
    case (size)
      SZ_BYTE: begin
        case (addr)
          2'd0:    merged_word[7:0]   = wdata[7:0];
          2'd1:    merged_word[15:8]  = wdata[7:0];
          2'd2:    merged_word[23:16] = wdata[7:0];
          default: merged_word[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr[1]) merged_word[31:16] = wdata[15:0];
        else         merged_word[15:0]  = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/dm_rmw_ctrl.sv
// M-stage data-memory controller with sub-word read-modify-write.
// Word stores go straight through; byte/half stores take one stall.
module dm_rmw_ctrl
  import dm_rmw_ctrl_pkg::*;
#(
  parameter int DM_AW = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_sign,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             stall,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  output logic             err,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_we,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata
);

  dm_state_e   r_state;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_rdata_valid;
  logic        r_err;

  logic [31:0] w_hi;
  logic        w_illegal;
  logic        w_idle;
  logic        w_go;
  logic        w_st_word;
  logic        w_st_sub;
  logic        w_ld;
  logic        w_err;
  logic [31:0] w_word;
  logic [31:0] w_ext;
  logic [31:0] w_merged;

  // Classify the request and derive the DM strobes.
  always_comb begin
    w_hi      = req_addr >> (DM_AW + 2);
    w_illegal = (req_size == SZ_ILL)
              | ((req_size == SZ_HALF) & req_addr[0])
              | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
              | (w_hi != 32'd0);
    w_idle    = (r_state == IDLE);
    w_go      = req_valid & ~w_illegal;
    w_st_word = w_idle & w_go & req_we & ~size_is_sub(req_size);
    w_st_sub  = w_idle & w_go & req_we & size_is_sub(req_size);
    w_ld      = w_idle & w_go & ~req_we;
    w_err     = w_idle & req_valid & w_illegal;
    w_word    = (r_state == MERGE) ? r_merge : dm_rdata;
  end

  dm_lane_unit u_lane (
    .word        (w_word),
    .addr        (req_addr[1:0]),
    .size        (req_size),
    .sign        (req_sign),
    .wdata       (req_wdata),
    .ext_load    (w_ext),
    .merged_word (w_merged)
  );

  assign dm_addr     = req_addr[DM_AW+1:2];
  assign dm_wdata    = w_merged;
  assign dm_we       = ~Reset & (w_st_word | (r_state == MERGE));
  assign stall       = ~Reset & w_st_sub;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign err         = r_err;

  // FSM: latch the old word on a sub-word store, write it back merged.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_merge       <= 32'd0;
      r_rdata       <= 32'd0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdata_valid <= w_ld;
      r_err         <= w_err;
      if (w_ld) r_rdata <= w_ext;
      case (r_state)
        IDLE: begin
          if (w_st_sub) begin
            r_merge <= dm_rdata;
            r_state <= MERGE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// Directed self-checking bench for dm_rmw_ctrl.
// Inputs driven 1ns after posedge; comb outputs sampled at negedge.
module tb_dm_rmw_ctrl;

  localparam int AW = 12;

  logic          Clk;
  logic          Reset;
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_sign;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          stall;
  logic [31:0]   rdata;
  logic          rdata_valid;
  logic          err;
  logic [AW-1:0] dm_addr;
  logic          dm_we;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;

  logic [31:0] mem [0:(1<<AW)-1];
  int checks;
  int failures;
  int nstall;

  dm_rmw_ctrl #(.DM_AW(AW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_sign    (req_sign),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .err         (err),
    .dm_addr     (dm_addr),
    .dm_we       (dm_we),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  assign dm_rdata = mem[dm_addr];

  always @(posedge Clk) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
  end

  task automatic drive(input logic v, input logic we,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_size  = sz;
    req_sign  = sg;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #2;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL rst_stall got=%b exp=0", stall);
    end
    checks++;
    if (dm_we !== 1'b0) begin
      failures++; $display("FAIL rst_dm_we got=%b exp=0", dm_we);
    end
    checks++;
    if ({rdata_valid, err, rdata} !== 34'd0) begin
      failures++;
      $display("FAIL rst_regs got=%b%b_%h exp=00_0", rdata_valid, err, rdata);
    end
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic test_valid_low;
    @(posedge Clk); #1;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h77);
    @(negedge Clk);
    checks++;
    if ({dm_we, stall} !== 2'b00) begin
      failures++; $display("FAIL vlow_we_stall got=%b%b exp=00", dm_we, stall);
    end
    @(posedge Clk); #1;
    checks++;
    if ({err, rdata_valid} !== 2'b00) begin
      failures++; $display("FAIL vlow_pulse got=%b%b exp=00", err, rdata_valid);
    end
  endtask

  task automatic test_word_store;
    @(posedge Clk); #1;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge Clk);
    checks++;
    if ({dm_we, stall} !== 2'b10) begin
      failures++; $display("FAIL sw_we_stall got=%b%b exp=10", dm_we, stall);
    end
    checks++;
    if (dm_addr !== 12'd4) begin
      failures++; $display("FAIL sw_addr got=%h exp=4", dm_addr);
    end
    checks++;
    if (dm_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", dm_wdata);
    end
    @(posedge Clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]);
    end
  endtask

  task automatic test_byte_store;
    @(posedge Clk); #1;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
    @(negedge Clk);
    checks++;
    if ({stall, dm_we} !== 2'b10) begin
      failures++; $display("FAIL sb_c0 got=%b%b exp=10", stall, dm_we);
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    checks++;
    if ({stall, dm_we} !== 2'b01) begin
      failures++; $display("FAIL sb_c1 got=%b%b exp=01", stall, dm_we);
    end
    checks++;
    if (dm_wdata !== 32'hDEAABEEF) begin
      failures++; $display("FAIL sb_wdata got=%h exp=deaabeef", dm_wdata);
    end
    @(posedge Clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem[4] !== 32'hDEAABEEF) begin
      failures++; $display("FAIL sb_mem got=%h exp=deaabeef", mem[4]);
    end
    @(negedge Clk);
    checks++;
    if (dm_we !== 1'b0) begin
      failures++; $display("FAIL sb_done_we got=%b exp=0", dm_we);
    end
  endtask

  task automatic test_load;
    @(posedge Clk); #1;
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    @(negedge Clk);
    checks++;
    if ({stall, dm_we} !== 2'b00) begin
      failures++; $display("FAIL lb_comb got=%b%b exp=00", stall, dm_we);
    end
    @(posedge Clk); #1;
    checks++;
    if ({rdata_valid, rdata} !== {1'b1, 32'hFFFFFFAA}) begin
      failures++;
      $display("FAIL lb_rdata got=%b_%h exp=1_ffffffaa", rdata_valid, rdata);
    end
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    @(posedge Clk); #1;
    checks++;
    if ({rdata_valid, rdata} !== {1'b1, 32'h0000DEAA}) begin
      failures++;
      $display("FAIL lhu_rdata got=%b_%h exp=1_0000deaa", rdata_valid, rdata);
    end
    req_valid = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if ({rdata_valid, rdata} !== {1'b0, 32'h0000DEAA}) begin
      failures++;
      $display("FAIL ld_hold got=%b_%h exp=0_0000deaa", rdata_valid, rdata);
    end
  endtask

  task automatic test_errors;
    @(posedge Clk); #1;
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h13, 32'h1234);
    @(negedge Clk);
    checks++;
    if ({dm_we, stall} !== 2'b00) begin
      failures++; $display("FAIL sh_mis_comb got=%b%b exp=00", dm_we, stall);
    end
    @(posedge Clk); #1;
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL sh_mis_err got=%b exp=1", err);
    end
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h4000, 32'h55555555);
    @(negedge Clk);
    checks++;
    if ({dm_we, stall} !== 2'b00) begin
      failures++; $display("FAIL sw_oor_comb got=%b%b exp=00", dm_we, stall);
    end
    @(posedge Clk); #1;
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL sw_oor_err got=%b exp=1", err);
    end
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    @(posedge Clk); #1;
    checks++;
    if ({err, rdata_valid} !== 2'b10) begin
      failures++; $display("FAIL sz11_err got=%b%b exp=10", err, rdata_valid);
    end
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
    @(posedge Clk); #1;
    checks++;
    if ({err, rdata_valid} !== 2'b10) begin
      failures++; $display("FAIL lw_mis_err got=%b%b exp=10", err, rdata_valid);
    end
    req_valid = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_pulse got=%b exp=0", err);
    end
  endtask

  task automatic test_reset_merge;
    mem[8] = 32'h12345678;
    @(posedge Clk); #1;
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h20, 32'h0000BEEF);
    @(negedge Clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL rm_stall got=%b exp=1", stall);
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    checks++;
    if ({dm_we, stall} !== 2'b00) begin
      failures++; $display("FAIL rm_comb got=%b%b exp=00", dm_we, stall);
    end
    checks++;
    if ({rdata_valid, err, rdata} !== 34'd0) begin
      failures++;
      $display("FAIL rm_regs got=%b%b_%h exp=00_0", rdata_valid, err, rdata);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    req_valid = 1'b0;
    @(negedge Clk);
    checks++;
    if (dm_we !== 1'b0) begin
      failures++; $display("FAIL rm_idle_we got=%b exp=0", dm_we);
    end
    @(posedge Clk); #1;
    checks++;
    if (mem[8] !== 32'h12345678) begin
      failures++; $display("FAIL rm_mem got=%h exp=12345678", mem[8]);
    end
  endtask

  task automatic test_back_to_back;
    nstall = 0;
    @(posedge Clk); #1;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055);
    @(negedge Clk);
    if (stall) nstall++;
    checks++;
    if (dm_we !== 1'b0) begin
      failures++; $display("FAIL b2b_sb_c0 got=%b exp=0", dm_we);
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    if (stall) nstall++;
    checks++;
    if ({dm_we, dm_wdata} !== {1'b1, 32'hDEAABE55}) begin
      failures++;
      $display("FAIL b2b_sb_c1 got=%b_%h exp=1_deaabe55", dm_we, dm_wdata);
    end
    @(posedge Clk); #1;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D);
    @(negedge Clk);
    if (stall) nstall++;
    checks++;
    if ({dm_we, dm_addr, dm_wdata} !== {1'b1, 12'd5, 32'hCAFEF00D}) begin
      failures++;
      $display("FAIL b2b_sw got=%b_%h_%h exp=1_005_cafef00d",
               dm_we, dm_addr, dm_wdata);
    end
    @(posedge Clk); #1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge Clk);
    if (stall) nstall++;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    checks++;
    if ({rdata_valid, rdata} !== {1'b1, 32'hDEAABE55}) begin
      failures++;
      $display("FAIL b2b_lw got=%b_%h exp=1_deaabe55", rdata_valid, rdata);
    end
    checks++;
    if (nstall !== 1) begin
      failures++; $display("FAIL b2b_stalls got=%0d exp=1", nstall);
    end
    checks++;
    if ({mem[4], mem[5]} !== {32'hDEAABE55, 32'hCAFEF00D}) begin
      failures++;
      $display("FAIL b2b_mem got=%h_%h exp=deaabe55_cafef00d", mem[4], mem[5]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    test_reset;
    test_valid_low;
    test_word_store;
    test_byte_store;
    test_load;
    test_errors;
    test_reset_merge;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_rmw_ctrl.md
DM_RMW_CTRL -- requirements
Module: dm_rmw_ctrl

Interface
REQ-001 SHALL have parameter DM_AW, default 12, meaning the DM word-address width; the valid byte range is [0, 4*2^DM_AW).
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: the M-stage instruction is a load or a store.
REQ-005 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-007 SHALL have port req_sign, input, 1 bit: sign-extend sub-word loads.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address (ALU result).
REQ-009 SHALL have port req_wdata, input, 32 bits: forwarded store data; sub-word data is in the low bits.
REQ-010 SHALL have port stall, output, 1 bit: hold the F/D/E/M registers and keep every req_* input stable.
REQ-011 SHALL have port rdata, output, 32 bits: registered, extended load result.
REQ-012 SHALL have port rdata_valid, output, 1 bit: one-cycle pulse qualifying rdata.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse for a misaligned, out-of-range or illegal-size request.
REQ-014 SHALL have port dm_addr, output, DM_AW bits: word index, equal to req_addr[DM_AW+1:2].
REQ-015 SHALL have port dm_we, output, 1 bit: DM word write enable.
REQ-016 SHALL have port dm_wdata, output, 32 bits: full word to write.
REQ-017 SHALL have port dm_rdata, input, 32 bits: DM asynchronous (combinational) read data at dm_addr.

Function
REQ-018 SHALL implement a 2-state FSM with states IDLE and MERGE.
REQ-019 SHALL flag a request illegal when any of these holds: req_size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:DM_AW+2] nonzero.
REQ-020 SHALL, for an illegal request in IDLE, keep dm_we=0, keep stall=0, pulse err the next cycle, and keep the state IDLE.
REQ-021 SHALL, for a legal word store in IDLE, drive dm_we=1 and dm_wdata=req_wdata in the same cycle, with stall=0 and the state staying IDLE (zero added latency).
REQ-022 SHALL, for a legal sub-word store in IDLE, drive stall=1 and dm_we=0, latch dm_rdata into a merge register, and go to MERGE.
REQ-023 SHALL, in MERGE, drive dm_we=1 with the latched word, replacing byte lane addr[1:0] (byte) or half lane addr[1] (half) with req_wdata low bits; SHALL hold stall=0 and return to IDLE (sub-word store = 2 cycles).
REQ-024 SHALL, for a legal load in IDLE, register the extracted lane into rdata, zero- or sign-extended per req_sign, and pulse rdata_valid the next cycle; stall=0.
REQ-025 SHALL keep dm_addr combinationally derived from req_addr in both states; req_* inputs are stable in MERGE per REQ-010.
REQ-026 SHALL ignore req_valid=0 entirely: dm_we=0, no pulses, state unchanged in IDLE.
REQ-027 SHALL hold rdata at its last value between loads.
REQ-028 SHALL give a store back-to-back after a sub-word store (next cycle in IDLE) the same treatment as any other store, with no bubble beyond REQ-023.

Reset
REQ-029 SHALL, on Reset=1 (asynchronous), force: state=IDLE, merge register=0, rdata=0, rdata_valid=0, err=0; combinationally stall=0 and dm_we=0.
REQ-030 SHALL, on reset asserted while in MERGE, abandon the pending write, with no DM write occurring.

Structure
REQ-031 SHALL place the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state encoding in the shared pipeline definitions package used by the controllers.
REQ-032 SHALL implement lane extract/merge as one combinational sub-module, dm_lane_unit (inputs word, addr[1:0], size, sign, wdata; outputs ext_load, merged_word).

Verification
REQ-033 SHALL cover: sw addr 0x10 data 0xDEADBEEF -> same cycle dm_we=1, dm_addr=4, dm_wdata=0xDEADBEEF, stall never asserted.
REQ-034 SHALL cover: DM[4]=0xDEADBEEF, sb addr 0x12 data 0x000000AA -> cycle0 stall=1, dm_we=0; cycle1 dm_we=1, dm_wdata=0xDEAABEEF.
REQ-035 SHALL cover: DM[4]=0xDEAABEEF, lb addr 0x12 sign=1 -> next cycle rdata=0xFFFFFFAA, rdata_valid=1; lhu addr 0x12 -> rdata=0x0000DEAA.
REQ-036 SHALL cover: sh addr 0x13 -> err pulse, no dm_we, stall=0; sw addr 0x4000 with DM_AW=12 -> err pulse.
REQ-037 SHALL cover: Reset pulsed during MERGE of sh addr 0x20 -> dm_we stays 0, state IDLE, DM[8] unchanged, all outputs at reset values.
REQ-038 SHALL cover: sb 0x10 then sw 0x14 then lw 0x10 back-to-back -> exactly one stall cycle, DM updated correctly, rdata reflects the merged word.
